machine_timer_device: RTL and testbench

// - Memory-mapped RISC-V machine timer (64-bit mtime/mtimecmp) with programmable prescaler and timer interrupt.
// - Sits directly downstream of system_bus: connects to one device slot (address, read/write request/response, data, strobe).
// - Base-address decode is done by system_bus; this block decodes only the word offset.

---
 rtl/machine_timer_device_pkg.sv | 27 ++
 rtl/machine_timer_tick_gen.sv | 32 +++
 rtl/machine_timer_device.sv | 121 ++++++++++++
 tb/tb_machine_timer_device.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_timer_device_pkg.sv
// Register map, reset constants and byte-strobe merge helper for the machine timer.
package machine_timer_device_pkg;

  localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL        = 3'd4;
  localparam logic [2:0] OFF_PRESCALE    = 3'd5;

  localparam int          CTRL_ENABLE_BIT   = 0;
  localparam logic [63:0] MTIME_RESET       = 64'd0;
  localparam logic [63:0] MTIMECMP_RESET    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic        CTRL_ENABLE_RESET = 1'b1;

  function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/machine_timer_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE+1 enabled cycles; counter frozen while disabled.
module machine_timer_tick_gen (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic [15:0] prescale_i,
  input  logic        clear_i,
  output logic        tick_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    tick_o  = enable_i && (count_q == prescale_i);
    count_d = count_q;
    // A prescale rewrite restarts the period from zero regardless of enable.
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = tick_o ? '0 : count_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/machine_timer_device.sv
// Memory-mapped RISC-V machine timer (64-bit mtime/mtimecmp, prescaled tick, level irq)
// on one system_bus device slot; every access is acknowledged exactly one cycle later.
module machine_timer_device
  import machine_timer_device_pkg::*;
#(
  parameter logic [15:0] RESET_PRESCALE = 16'd0
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [31:0] rw_address_i,
  output logic [31:0] read_data_o,
  input  logic        read_request_i,
  output logic        read_response_o,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  write_strobe_i,
  input  logic        write_request_i,
  output logic        write_response_o,
  output logic        timer_irq_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        enable_q, enable_d;
  logic [15:0] prescale_q, prescale_d;
  logic [31:0] read_data_q, read_data_d;
  logic        read_response_q, read_response_d;
  logic        write_response_q, write_response_d;
  logic        timer_irq_q, timer_irq_d;
  logic        tick;
  logic        prescale_clear;
  logic [31:0] rd_mux;
  logic [2:0]  offset;
  logic        unused_addr;

  assign offset      = rw_address_i[4:2];
  assign unused_addr = ^{rw_address_i[31:5], rw_address_i[1:0]};

  machine_timer_tick_gen u_tick_gen (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .enable_i   (enable_q),
    .prescale_i (prescale_q),
    .clear_i    (prescale_clear),
    .tick_o     (tick)
  );

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_MTIME_LO:    rd_mux = mtime_q[31:0];
      OFF_MTIME_HI:    rd_mux = mtime_q[63:32];
      OFF_MTIMECMP_LO: rd_mux = mtimecmp_q[31:0];
      OFF_MTIMECMP_HI: rd_mux = mtimecmp_q[63:32];
      OFF_CTRL:        rd_mux = {31'd0, enable_q};
      OFF_PRESCALE:    rd_mux = {16'd0, prescale_q};
      default:         rd_mux = '0;
    endcase
  end

  always_comb begin
    mtime_d          = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d       = mtimecmp_q;
    enable_d         = enable_q;
    prescale_d       = prescale_q;
    prescale_clear   = 1'b0;
    read_data_d      = read_request_i ? rd_mux : read_data_q;
    read_response_d  = read_request_i;
    write_response_d = write_request_i;
    timer_irq_d      = (mtime_q >= mtimecmp_q);

    // A write to either mtime half replaces the whole next value, so the tick is dropped for both halves.
    if (write_request_i) begin
      case (offset)
        OFF_MTIME_LO:
          mtime_d = {mtime_q[63:32], apply_strobe(mtime_q[31:0], write_data_i, write_strobe_i)};
        OFF_MTIME_HI:
          mtime_d = {apply_strobe(mtime_q[63:32], write_data_i, write_strobe_i), mtime_q[31:0]};
        OFF_MTIMECMP_LO:
          mtimecmp_d[31:0] = apply_strobe(mtimecmp_q[31:0], write_data_i, write_strobe_i);
        OFF_MTIMECMP_HI:
          mtimecmp_d[63:32] = apply_strobe(mtimecmp_q[63:32], write_data_i, write_strobe_i);
        OFF_CTRL:
          if (write_strobe_i[0]) enable_d = write_data_i[CTRL_ENABLE_BIT];
        OFF_PRESCALE: begin
          prescale_clear = 1'b1;
          if (write_strobe_i[0]) prescale_d[7:0]  = write_data_i[7:0];
          if (write_strobe_i[1]) prescale_d[15:8] = write_data_i[15:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      mtime_q          <= MTIME_RESET;
      mtimecmp_q       <= MTIMECMP_RESET;
      enable_q         <= CTRL_ENABLE_RESET;
      prescale_q       <= RESET_PRESCALE;
      read_data_q      <= '0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
      timer_irq_q      <= 1'b0;
    end else begin
      mtime_q          <= mtime_d;
      mtimecmp_q       <= mtimecmp_d;
      enable_q         <= enable_d;
      prescale_q       <= prescale_d;
      read_data_q      <= read_data_d;
      read_response_q  <= read_response_d;
      write_response_q <= write_response_d;
      timer_irq_q      <= timer_irq_d;
    end
  end

  assign read_data_o      = read_data_q;
  assign read_response_o  = read_response_q;
  assign write_response_o = write_response_q;
  assign timer_irq_o      = timer_irq_q;

endmodule

// File: tb/tb_machine_timer_device.sv
// Scenario bench for machine_timer_device; expected read data queued at issue, popped at response.
module tb_machine_timer_device;
  import machine_timer_device_pkg::*;

  localparam logic [15:0] RST_PS = 16'h0007;

  logic        clock_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [31:0] rw_address_i = '0;
  logic [31:0] read_data_o;
  logic        read_request_i = 1'b0;
  logic        read_response_o;
  logic [31:0] write_data_i = '0;
  logic [3:0]  write_strobe_i = '0;
  logic        write_request_i = 1'b0;
  logic        write_response_o;
  logic        timer_irq_o;

  int total = 0;
  int bad = 0;
  logic [31:0] rd_exp_q[$];
  logic [31:0] got, exp;
  logic        rsp, wrsp;

  machine_timer_device #(.RESET_PRESCALE(RST_PS)) dut (
    .clock_i          (clock_i),
    .reset_n_i        (reset_n_i),
    .rw_address_i     (rw_address_i),
    .read_data_o      (read_data_o),
    .read_request_i   (read_request_i),
    .read_response_o  (read_response_o),
    .write_data_i     (write_data_i),
    .write_strobe_i   (write_strobe_i),
    .write_request_i  (write_request_i),
    .write_response_o (write_response_o),
    .timer_irq_o      (timer_irq_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic idle(input int n);
    repeat (n) @(negedge clock_i);
  endtask

  task automatic do_read(input logic [2:0] off, output logic [31:0] data, output logic resp);
    rw_address_i   = {27'd0, off, 2'b00};
    read_request_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    read_request_i = 1'b0;
    data = read_data_o;
    resp = read_response_o;
  endtask

  task automatic do_write(input logic [2:0] off, input logic [31:0] data,
                          input logic [3:0] strb, output logic resp);
    rw_address_i    = {27'd0, off, 2'b00};
    write_data_i    = data;
    write_strobe_i  = strb;
    write_request_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    write_request_i = 1'b0;
    write_strobe_i  = 4'h0;
    resp = write_response_o;
  endtask

  task automatic test_reset();
    logic [2:0]  offs[4];
    logic [31:0] exps[4];
    offs = '{OFF_CTRL, OFF_MTIMECMP_HI, OFF_MTIMECMP_LO, OFF_PRESCALE};
    exps = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {16'd0, RST_PS}};
    reset_n_i = 1'b0;
    repeat (3) @(negedge clock_i);
    total++;
    if ({read_data_o, read_response_o, write_response_o, timer_irq_o} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs: data=%h rrsp=%b wrsp=%b irq=%b want all 0",
               read_data_o, read_response_o, write_response_o, timer_irq_o);
    end
    reset_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_exp_q.push_back(exps[i]);
      do_read(offs[i], got, rsp);
      exp = rd_exp_q.pop_front();
      total++;
      if (got !== exp || rsp !== 1'b1) begin
        bad++;
        $display("FAIL reset_read[%0d]: got=%h rsp=%b want=%h rsp=1", i, got, rsp, exp);
      end
    end
  endtask

  task automatic test_prescale();
    logic [31:0] exps[3];
    exps = '{32'd4, 32'd4, 32'd5};
    do_write(OFF_CTRL, 32'd0, 4'hF, wrsp);
    do_write(OFF_MTIME_LO, 32'd0, 4'hF, wrsp);
    do_write(OFF_MTIME_HI, 32'd0, 4'hF, wrsp);
    do_write(OFF_PRESCALE, 32'd3, 4'hF, wrsp);
    do_write(OFF_CTRL, 32'd1, 4'hF, wrsp);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) idle(16);
      if (i == 1) begin
        do_write(OFF_CTRL, 32'd0, 4'hF, wrsp);
        idle(20);
      end
      if (i == 2) begin
        // counter was frozen at 2: two enabled edges reach the match
        do_write(OFF_CTRL, 32'd1, 4'hF, wrsp);
        idle(1);
        do_write(OFF_CTRL, 32'd0, 4'hF, wrsp);
      end
      rd_exp_q.push_back(exps[i]);
      do_read(OFF_MTIME_LO, got, rsp);
      exp = rd_exp_q.pop_front();
      total++;
      if (got !== exp || rsp !== 1'b1) begin
        bad++;
        $display("FAIL prescale_step[%0d]: got=%h rsp=%b want=%h", i, got, rsp, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] offs[2];
    offs = '{OFF_MTIME_LO, OFF_MTIME_HI};
    do_write(OFF_CTRL, 32'd0, 4'hF, wrsp);
    do_write(OFF_MTIME_LO, 32'hFFFF_FFFF, 4'hF, wrsp);
    do_write(OFF_MTIME_HI, 32'hFFFF_FFFF, 4'hF, wrsp);
    do_write(OFF_PRESCALE, 32'd0, 4'hF, wrsp);
    total++;
    if (timer_irq_o !== 1'b1) begin
      bad++;
      $display("FAIL irq_at_max: got=%b want=1", timer_irq_o);
    end
    do_write(OFF_CTRL, 32'd1, 4'hF, wrsp);
    do_write(OFF_CTRL, 32'd0, 4'hF, wrsp);
    for (int i = 0; i < 2; i++) begin
      rd_exp_q.push_back(32'd0);
      do_read(offs[i], got, rsp);
      exp = rd_exp_q.pop_front();
      total++;
      if (got !== exp || rsp !== 1'b1) begin
        bad++;
        $display("FAIL wrap[%0d]: got=%h rsp=%b want=%h", i, got, rsp, exp);
      end
    end
    total++;
    if (timer_irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_after_wrap: got=%b want=0", timer_irq_o);
    end
  endtask

  task automatic test_strobe();
    logic [2:0]  offs[3];
    logic [31:0] exps[3];
    offs = '{OFF_MTIME_LO, OFF_MTIME_HI, OFF_MTIME_HI};
    exps = '{32'h0000_CC01, 32'd0, 32'h1234_0000};
    do_write(OFF_MTIME_LO, 32'd0, 4'hF, wrsp);
    do_write(OFF_MTIME_HI, 32'd0, 4'hF, wrsp);
    do_write(OFF_PRESCALE, 32'd0, 4'hF, wrsp);
    do_write(OFF_CTRL, 32'd1, 4'hF, wrsp);
    // byte-1 write lands while ticking every cycle; the next edge adds exactly one tick
    do_write(OFF_MTIME_LO, 32'hAABB_CCDD, 4'b0010, wrsp);
    do_write(OFF_CTRL, 32'd0, 4'hF, wrsp);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        do_write(OFF_MTIME_HI, 32'hFFFF_FFFF, 4'b0000, wrsp);
        total++;
        if (wrsp !== 1'b1) begin
          bad++;
          $display("FAIL strobe_zero_resp: got=%b want=1", wrsp);
        end
      end
      if (i == 2) do_write(OFF_MTIME_HI, 32'h1234_5678, 4'b1100, wrsp);
      rd_exp_q.push_back(exps[i]);
      do_read(offs[i], got, rsp);
      exp = rd_exp_q.pop_front();
      total++;
      if (got !== exp || rsp !== 1'b1) begin
        bad++;
        $display("FAIL strobe[%0d]: got=%h rsp=%b want=%h", i, got, rsp, exp);
      end
    end
  endtask

  task automatic test_irq();
    do_write(OFF_CTRL, 32'd0, 4'hF, wrsp);
    do_write(OFF_MTIMECMP_HI, 32'd0, 4'hF, wrsp);
    do_write(OFF_MTIMECMP_LO, 32'd100, 4'hF, wrsp);
    do_write(OFF_MTIME_HI, 32'd0, 4'hF, wrsp);
    do_write(OFF_MTIME_LO, 32'd95, 4'hF, wrsp);
    do_write(OFF_PRESCALE, 32'd0, 4'hF, wrsp);
    do_write(OFF_CTRL, 32'd1, 4'hF, wrsp);
    // mtime reaches 100 after the 5th enabled edge; irq follows one edge later
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock_i);
      total++;
      if (timer_irq_o !== (k >= 6)) begin
        bad++;
        $display("FAIL irq_rise[%0d]: got=%b want=%b", k, timer_irq_o, (k >= 6));
      end
    end
    do_write(OFF_MTIMECMP_LO, 32'd200, 4'hF, wrsp);
    total++;
    if (timer_irq_o !== 1'b1) begin
      bad++;
      $display("FAIL irq_hold: got=%b want=1", timer_irq_o);
    end
    @(negedge clock_i);
    total++;
    if (timer_irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_fall: got=%b want=0", timer_irq_o);
    end
    do_write(OFF_CTRL, 32'd0, 4'hF, wrsp);
  endtask

  task automatic test_back_to_back();
    rw_address_i   = {27'd0, OFF_MTIMECMP_LO, 2'b00};
    read_request_i = 1'b1;
    rd_exp_q.push_back(32'd200);
    @(posedge clock_i);
    @(negedge clock_i);
    exp = rd_exp_q.pop_front();
    total++;
    if (read_response_o !== 1'b1 || read_data_o !== exp) begin
      bad++;
      $display("FAIL btb_rd0: rsp=%b data=%h want rsp=1 data=%h", read_response_o, read_data_o, exp);
    end
    read_request_i  = 1'b0;
    rw_address_i    = {27'd0, 3'd7, 2'b00};
    write_data_i    = 32'hFFFF_FFFF;
    write_strobe_i  = 4'hF;
    write_request_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    total++;
    if (write_response_o !== 1'b1 || read_response_o !== 1'b0 || read_data_o !== 32'd200) begin
      bad++;
      $display("FAIL btb_wr1: wrsp=%b rrsp=%b data=%h want 1 0 000000c8",
               write_response_o, read_response_o, read_data_o);
    end
    write_request_i = 1'b0;
    write_strobe_i  = 4'h0;
    read_request_i  = 1'b1;
    rd_exp_q.push_back(32'd0);
    @(posedge clock_i);
    @(negedge clock_i);
    exp = rd_exp_q.pop_front();
    total++;
    if (read_response_o !== 1'b1 || write_response_o !== 1'b0 || read_data_o !== exp) begin
      bad++;
      $display("FAIL btb_rd2: rrsp=%b wrsp=%b data=%h want 1 0 %h",
               read_response_o, write_response_o, read_data_o, exp);
    end
    read_request_i = 1'b0;
    @(posedge clock_i);
    @(negedge clock_i);
    total++;
    if (read_response_o !== 1'b0 || write_response_o !== 1'b0) begin
      bad++;
      $display("FAIL btb_idle3: rrsp=%b wrsp=%b want 0 0", read_response_o, write_response_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0]  offs[3];
    logic [31:0] wdat[3];
    logic [31:0] exps[3];
    offs = '{OFF_PRESCALE, OFF_PRESCALE, OFF_CTRL};
    wdat = '{32'h0000_0055, 32'hABCD_1234, 32'hFFFF_FFFE};
    exps = '{32'h0000_0055, 32'h0000_1234, 32'd0};
    rw_address_i    = {27'd0, OFF_PRESCALE, 2'b00};
    write_data_i    = 32'h55;
    write_strobe_i  = 4'hF;
    write_request_i = 1'b1;
    read_request_i  = 1'b1;
    rd_exp_q.push_back(32'd0);
    @(posedge clock_i);
    @(negedge clock_i);
    write_request_i = 1'b0;
    read_request_i  = 1'b0;
    exp = rd_exp_q.pop_front();
    total++;
    if (read_data_o !== exp || read_response_o !== 1'b1 || write_response_o !== 1'b1) begin
      bad++;
      $display("FAIL rw_same_cycle: data=%h rrsp=%b wrsp=%b want %h 1 1",
               read_data_o, read_response_o, write_response_o, exp);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) do_write(offs[i], wdat[i], 4'hF, wrsp);
      rd_exp_q.push_back(exps[i]);
      do_read(offs[i], got, rsp);
      exp = rd_exp_q.pop_front();
      total++;
      if (got !== exp || rsp !== 1'b1) begin
        bad++;
        $display("FAIL raz_wi[%0d]: got=%h rsp=%b want=%h", i, got, rsp, exp);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    logic [2:0]  offs[2];
    logic [31:0] exps[2];
    offs = '{OFF_PRESCALE, OFF_CTRL};
    exps = '{{16'd0, RST_PS}, 32'd1};
    rw_address_i   = {27'd0, OFF_PRESCALE, 2'b00};
    read_request_i = 1'b1;
    rd_exp_q.push_back(32'h0000_1234);
    @(posedge clock_i);
    @(negedge clock_i);
    exp = rd_exp_q.pop_front();
    total++;
    if (read_response_o !== 1'b1 || read_data_o !== exp) begin
      bad++;
      $display("FAIL rif_rd0: rsp=%b data=%h want 1 %h", read_response_o, read_data_o, exp);
    end
    read_request_i  = 1'b0;
    rw_address_i    = {27'd0, OFF_MTIME_HI, 2'b00};
    write_data_i    = 32'h1;
    write_strobe_i  = 4'hF;
    write_request_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    total++;
    if (write_response_o !== 1'b1) begin
      bad++;
      $display("FAIL rif_wr1: wrsp=%b want 1", write_response_o);
    end
    write_request_i = 1'b0;
    write_strobe_i  = 4'h0;
    rw_address_i    = {27'd0, OFF_CTRL, 2'b00};
    read_request_i  = 1'b1;
    reset_n_i       = 1'b0;
    @(posedge clock_i);
    @(negedge clock_i);
    total++;
    if (read_response_o !== 1'b0 || write_response_o !== 1'b0 || read_data_o !== 32'd0) begin
      bad++;
      $display("FAIL rif_no_resp: rrsp=%b wrsp=%b data=%h want 0 0 0",
               read_response_o, write_response_o, read_data_o);
    end
    read_request_i = 1'b0;
    reset_n_i      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_exp_q.push_back(exps[i]);
      do_read(offs[i], got, rsp);
      exp = rd_exp_q.pop_front();
      total++;
      if (got !== exp || rsp !== 1'b1) begin
        bad++;
        $display("FAIL rif_after[%0d]: got=%h rsp=%b want=%h", i, got, rsp, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_prescale();
    test_wrap();
    test_strobe();
    test_irq();
    test_back_to_back();
    test_simultaneous();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
